// File: rtl/tron_move_engine_if.sv
// Engine-side bus to the occupancy RAM and the vga_adapter plot mux.
// master = move engine, slave = RAM/display side.
interface tron_move_engine_if #(
   parameter int X_W = 8,
   parameter int Y_W = 7
);
   logic           occ_rd;
   logic [X_W-1:0] occ_x;
   logic [Y_W-1:0] occ_y;
   logic           occ_hit;
   logic           plot;
   logic [X_W-1:0] plot_x;
   logic [Y_W-1:0] plot_y;
   logic [2:0]     plot_colour;

   modport master (
      output occ_rd, occ_x, occ_y, plot, plot_x, plot_y, plot_colour,
      input  occ_hit
   );
   modport slave (
      input  occ_rd, occ_x, occ_y, plot, plot_x, plot_y, plot_colour,
      output occ_hit
   );
endinterface

// File: rtl/tron_move_engine.sv
// Tick-driven light-cycle movement engine: steps each live head, checks border/head-on/trail hits, plots survivors.
// Build option TRON_BORDER_WRAP_EN: heads wrap around the grid border instead of crashing.
module tron_move_engine #(
   parameter int NUM_PLAYERS = 2,
   parameter int X_W         = 8,
   parameter int Y_W         = 7,
   parameter int X_MAX       = 159,
   parameter int Y_MAX       = 119,
   parameter int TICK_DIV    = 2000000,
   parameter logic [NUM_PLAYERS*X_W-1:0] START_X   = {8'd159, 8'd0},
   parameter logic [NUM_PLAYERS*Y_W-1:0] START_Y   = {7'd119, 7'd0},
   parameter logic [NUM_PLAYERS*2-1:0]   START_DIR = {2'd2, 2'd0},
   parameter logic [NUM_PLAYERS*3-1:0]   COLOURS   = {3'b010, 3'b101}
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [2*NUM_PLAYERS-1:0]   dir_in,
   input  logic [NUM_PLAYERS-1:0]     dir_valid,
   tron_move_engine_if.master         bus,
   output logic [X_W*NUM_PLAYERS-1:0] head_x,
   output logic [Y_W*NUM_PLAYERS-1:0] head_y,
   output logic [NUM_PLAYERS-1:0]     crash,
   output logic                       game_over,
   output logic                       busy
);
   localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam int CW = $clog2(TICK_DIV);
`ifdef TRON_BORDER_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, INIT, WAIT, MOVE, QUERY, CHECK, PLOT, OVER} state_t;
   state_t state;

   logic [PW-1:0] p, p_inc;
   logic [CW-1:0] cnt;
   logic [NUM_PLAYERS-1:0][X_W-1:0] hx, nx_x;
   logic [NUM_PLAYERS-1:0][Y_W-1:0] hy, nx_y;
   logic [NUM_PLAYERS-1:0][1:0]     dir, pend;
   logic [NUM_PLAYERS-1:0]          nx_vld, hit_mask, crash_nx;
   logic [X_W-1:0] mx;
   logic [Y_W-1:0] my;
   logic [1:0]     eff;
   logic           oob, edge_crash, last, done;

   assign head_x = hx;
   assign head_y = hy;
   assign p_inc  = p + 1'b1;
   assign last   = (p == PW'(NUM_PLAYERS - 1));
   // Opposite directions differ only in bit 1, so a reversal request keeps the current heading.
   assign eff    = ((pend[p] ^ dir[p]) == 2'b10) ? dir[p] : pend[p];

   always_comb begin
      mx  = hx[p];
      my  = hy[p];
      oob = 1'b0;
      case (eff)
         2'd0: if (hx[p] == X_W'(X_MAX)) begin oob = 1'b1; mx = '0; end
               else mx = hx[p] + 1'b1;
         2'd1: if (hy[p] == Y_W'(Y_MAX)) begin oob = 1'b1; my = '0; end
               else my = hy[p] + 1'b1;
         2'd2: if (hx[p] == '0) begin oob = 1'b1; mx = X_W'(X_MAX); end
               else mx = hx[p] - 1'b1;
         default: if (hy[p] == '0) begin oob = 1'b1; my = Y_W'(Y_MAX); end
                  else my = hy[p] - 1'b1;
      endcase
   end

   assign edge_crash = oob & ~WRAP;

   // Only players already stepped this tick have nx_vld set, i.e. q < p.
   always_comb begin
      for (int q = 0; q < NUM_PLAYERS; q++)
         hit_mask[q] = nx_vld[q] && (nx_x[q] == mx) && (nx_y[q] == my);
   end

   // done: current player is finished for this tick (skipped, crashed or plotted).
   always_comb begin
      crash_nx = crash;
      done     = 1'b0;
      case (state)
         MOVE: begin
            if (crash[p]) done = 1'b1;
            else if (edge_crash) begin crash_nx[p] = 1'b1; done = 1'b1; end
            else if (|hit_mask) begin
               crash_nx    = crash | hit_mask;
               crash_nx[p] = 1'b1;
               done        = 1'b1;
            end
         end
         CHECK: if (bus.occ_hit) begin crash_nx[p] = 1'b1; done = 1'b1; end
         PLOT:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         p               <= '0;
         cnt             <= '0;
         crash           <= '0;
         game_over       <= 1'b0;
         busy            <= 1'b0;
         nx_vld          <= '0;
         nx_x            <= '0;
         nx_y            <= '0;
         bus.occ_rd      <= 1'b0;
         bus.occ_x       <= '0;
         bus.occ_y       <= '0;
         bus.plot        <= 1'b0;
         bus.plot_x      <= '0;
         bus.plot_y      <= '0;
         bus.plot_colour <= '0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            hx[i]   <= START_X[i*X_W +: X_W];
            hy[i]   <= START_Y[i*Y_W +: Y_W];
            dir[i]  <= START_DIR[i*2 +: 2];
            pend[i] <= START_DIR[i*2 +: 2];
         end
      end else begin
         crash <= crash_nx;
         case (state)
            IDLE, OVER: if (start) begin
               for (int i = 0; i < NUM_PLAYERS; i++) begin
                  hx[i]   <= START_X[i*X_W +: X_W];
                  hy[i]   <= START_Y[i*Y_W +: Y_W];
                  dir[i]  <= START_DIR[i*2 +: 2];
                  pend[i] <= START_DIR[i*2 +: 2];
               end
               crash           <= '0;
               game_over       <= 1'b0;
               busy            <= 1'b1;
               p               <= '0;
               bus.plot        <= 1'b1;
               bus.plot_x      <= START_X[X_W-1:0];
               bus.plot_y      <= START_Y[Y_W-1:0];
               bus.plot_colour <= COLOURS[2:0];
               state           <= INIT;
            end
            INIT: if (last) begin
               bus.plot <= 1'b0;
               busy     <= 1'b0;
               cnt      <= '0;
               state    <= WAIT;
            end else begin
               p               <= p_inc;
               bus.plot_x      <= hx[p_inc];
               bus.plot_y      <= hy[p_inc];
               bus.plot_colour <= COLOURS[3*p_inc +: 3];
            end
            WAIT: if (cnt == CW'(TICK_DIV - 1)) begin
               cnt    <= '0;
               p      <= '0;
               busy   <= 1'b1;
               nx_vld <= '0;
               state  <= MOVE;
            end else cnt <= cnt + 1'b1;
            MOVE: if (!done) begin
               dir[p]     <= eff;
               nx_x[p]    <= mx;
               nx_y[p]    <= my;
               nx_vld[p]  <= 1'b1;
               bus.occ_rd <= 1'b1;
               bus.occ_x  <= mx;
               bus.occ_y  <= my;
               state      <= QUERY;
            end
            QUERY: begin
               bus.occ_rd <= 1'b0;
               state      <= CHECK;
            end
            CHECK: if (!done) begin
               bus.plot        <= 1'b1;
               bus.plot_x      <= nx_x[p];
               bus.plot_y      <= nx_y[p];
               bus.plot_colour <= COLOURS[3*p +: 3];
               hx[p]           <= nx_x[p];
               hy[p]           <= nx_y[p];
               state           <= PLOT;
            end
            PLOT: bus.plot <= 1'b0;
            default: state <= IDLE;
         endcase
         if (done) begin
            if (last) begin
               busy <= 1'b0;
               cnt  <= '0;
               if (|crash_nx) begin
                  game_over <= 1'b1;
                  state     <= OVER;
               end else state <= WAIT;
            end else begin
               p     <= p_inc;
               state <= MOVE;
            end
         end
         // Requests land after the start reload so a same-cycle request is kept.
         for (int i = 0; i < NUM_PLAYERS; i++)
            if (dir_valid[i]) pend[i] <= dir_in[2*i +: 2];
      end
   end
endmodule

// File: tb/tb_tron_move_engine.sv
// Directed bench for tron_move_engine: tick table plus hand sequences for reversal, last-wins, trail hit,
// head-on, border exit (or wrap) and mid-tick reset. Occupancy RAM modelled from the plot strobes.
module tb_tron_move_engine;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  dir_in = '0;
   logic [1:0]  dir_valid = '0;
   logic [15:0] head_x;
   logic [13:0] head_y;
   logic [1:0]  crash;
   logic        game_over, busy;

   tron_move_engine_if #(.X_W(8), .Y_W(7)) bus ();

   tron_move_engine #(.TICK_DIV(4)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .dir_in(dir_in), .dir_valid(dir_valid),
      .bus(bus), .head_x(head_x), .head_y(head_y), .crash(crash),
      .game_over(game_over), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;

   // Occupancy model and plot log; only this process writes them.
   bit occ_map [0:119][0:159];
   bit occ_clr = 1'b0, occ_force0 = 1'b0, obst_en = 1'b0;
   int obst_x = 0, obst_y = 0;
   int lx [0:4095], ly [0:4095], lc [0:4095];
   int plot_cnt = 0;

   always @(negedge clk) begin
      if (occ_clr)
         for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++) occ_map[y][x] = 1'b0;
      if (bus.plot && plot_cnt < 4096) begin
         lx[plot_cnt] = int'(bus.plot_x);
         ly[plot_cnt] = int'(bus.plot_y);
         lc[plot_cnt] = int'(bus.plot_colour);
         if (bus.plot_x < 160 && bus.plot_y < 120) occ_map[bus.plot_y][bus.plot_x] = 1'b1;
         plot_cnt = plot_cnt + 1;
      end
   end

   always @(posedge clk) begin
      if (!reset_n) bus.occ_hit <= 1'b0;
      else bus.occ_hit <= bus.occ_rd && !occ_force0 &&
                          ((bus.occ_x < 160 && bus.occ_y < 120 && occ_map[bus.occ_y][bus.occ_x]) ||
                           (obst_en && int'(bus.occ_x) == obst_x && int'(bus.occ_y) == obst_y));
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_plot(input string name, input int idx, input int x, input int y, input int c);
      n_chk++;
      if (idx >= plot_cnt) begin
         n_fail++;
         $display("FAIL %s: no plot #%0d, expected (%0d,%0d) c%0d", name, idx, x, y, c);
      end else if (lx[idx] != x || ly[idx] != y || lc[idx] != c) begin
         n_fail++;
         $display("FAIL %s: got (%0d,%0d) c%0d, expected (%0d,%0d) c%0d",
                  name, lx[idx], ly[idx], lc[idx], x, y, c);
      end
   endtask

   task automatic timeout(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: timed out waiting on busy", name);
   endtask

   // Waits for one busy period (INIT or a tick) to start and end.
   task automatic tick();
      int k;
      k = 0;
      while (!busy && k < 40) begin @(negedge clk); k++; end
      if (!busy) begin timeout("tick_start"); return; end
      k = 0;
      while (busy && k < 60) begin @(negedge clk); k++; end
      if (busy) timeout("tick_end");
   endtask

   task automatic pulse(input logic [1:0] dv, input logic [3:0] din);
      @(posedge clk); #1;
      dir_valid = dv; dir_in = din;
      @(posedge clk); #1;
      dir_valid = '0;
   endtask

   task automatic do_start();
      @(posedge clk); #1;
      start = 1'b1; occ_clr = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; occ_clr = 1'b0;
   endtask

   typedef struct {
      logic [1:0] dv;
      logic [3:0] din;
      int         np;
      int         x0, y0, c0, x1, y1, c1;
      logic [1:0] cr;
      logic       go;
   } vec_t;
   vec_t vt [4];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, k, total;
      logic [1:0] dv;
      logic [3:0] din;

      vt[0] = '{2'b00, 4'b0000, 2, 1, 0, 5, 158, 119, 2, 2'b00, 1'b0};
      vt[1] = '{2'b01, 4'b0010, 2, 2, 0, 5, 157, 119, 2, 2'b00, 1'b0};  // P0 reverse ignored
      vt[2] = '{2'b10, 4'b1100, 2, 3, 0, 5, 157, 118, 2, 2'b00, 1'b0};  // P1 up
      vt[3] = '{2'b11, 4'b1001, 2, 3, 1, 5, 156, 118, 2, 2'b00, 1'b0};  // P0 down, P1 left

      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_game_over", int'(game_over), 0);
      chk("rst_crash", int'(crash), 0);
      chk("rst_plot", int'(bus.plot), 0);
      chk("rst_occ_rd", int'(bus.occ_rd), 0);
      chk("rst_plot_xy", int'({bus.plot_x, bus.plot_y}), 0);
      chk("rst_head_x", int'(head_x), 16'h9F00);
      chk("rst_head_y", int'(head_y), 119 << 7);
      @(posedge clk); #1 reset_n = 1'b1;

      base = plot_cnt;
      do_start();
      tick();
      chk("init_plots", plot_cnt - base, 2);
      chk_plot("init_p0", base, 0, 0, 5);
      chk_plot("init_p1", base + 1, 159, 119, 2);

      for (int i = 0; i < 4; i++) begin
         if (vt[i].dv != 2'b00) pulse(vt[i].dv, vt[i].din);
         base = plot_cnt;
         tick();
         chk($sformatf("vec%0d_nplots", i), plot_cnt - base, vt[i].np);
         chk_plot($sformatf("vec%0d_p0", i), base, vt[i].x0, vt[i].y0, vt[i].c0);
         chk_plot($sformatf("vec%0d_p1", i), base + 1, vt[i].x1, vt[i].y1, vt[i].c1);
         chk($sformatf("vec%0d_crash", i), int'(crash), int'(vt[i].cr));
         chk($sformatf("vec%0d_go", i), int'(game_over), int'(vt[i].go));
      end

      // Two requests in one WAIT: the later (up) must win; start in WAIT must be ignored.
      @(posedge clk); #1;
      dir_valid = 2'b10; dir_in = 4'b0100; start = 1'b1;
      @(posedge clk); #1;
      dir_in = 4'b1100; start = 1'b0;
      @(posedge clk); #1;
      dir_valid = '0;
      base = plot_cnt;
      tick();
      chk("lastwin_nplots", plot_cnt - base, 2);
      chk_plot("lastwin_p0", base, 3, 2, 5);
      chk_plot("lastwin_p1", base + 1, 156, 117, 2);

      // Trail hit on P1's target cell.
      obst_en = 1'b1; obst_x = 156; obst_y = 116;
      base = plot_cnt;
      tick();
      chk("hit_nplots", plot_cnt - base, 1);
      chk_plot("hit_p0", base, 3, 3, 5);
      chk("hit_crash", int'(crash), 2);
      chk("hit_go", int'(game_over), 1);
      chk("hit_busy", int'(busy), 0);
      chk("hit_p1_head", int'({head_x[15:8], head_y[13:7]}), (156 << 7) | 117);
      obst_en = 1'b0;

      // Restart from OVER.
      base = plot_cnt;
      do_start();
      chk("restart_crash", int'(crash), 0);
      chk("restart_go", int'(game_over), 0);
      tick();
      chk("restart_plots", plot_cnt - base, 2);
      chk_plot("restart_p0", base, 0, 0, 5);
      chk_plot("restart_p1", base + 1, 159, 119, 2);

      // Async reset while P0's query is out.
      k = 0;
      while (!bus.occ_rd && k < 40) begin @(negedge clk); k++; end
      chk("query_seen", int'(bus.occ_rd), 1);
      base = plot_cnt;
      reset_n = 1'b0;
      #1;
      chk("midrst_occ_rd", int'(bus.occ_rd), 0);
      chk("midrst_occ_xy", int'({bus.occ_x, bus.occ_y}), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_head_x", int'(head_x), 16'h9F00);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("midrst_no_plot", plot_cnt - base, 0);
      chk("midrst_idle", int'(busy), 0);
      do_start();
      tick();
      chk("replay_plots", plot_cnt - base, 2);
      chk_plot("replay_p0", base, 0, 0, 5);
      chk_plot("replay_p1", base + 1, 159, 119, 2);

      // Head-on at (80,60) on tick 140.
      total = plot_cnt;
      for (int t = 1; t <= 140; t++) begin
         dv = '0; din = '0;
         if (t == 81) begin dv[0] = 1'b1; din[1:0] = 2'd1; end
         if (t == 2 || t == 4) begin dv[1] = 1'b1; din[3:2] = 2'd3; end
         if (t == 3) begin dv[1] = 1'b1; din[3:2] = 2'd0; end
         if (t == 62) begin dv[1] = 1'b1; din[3:2] = 2'd2; end
         if (dv != 2'b00) pulse(dv, din);
         base = plot_cnt;
         tick();
      end
      chk("headon_total_plots", plot_cnt - total, 279);
      chk("headon_nplots", plot_cnt - base, 1);
      chk_plot("headon_p0", base, 80, 60, 5);
      chk("headon_crash", int'(crash), 3);
      chk("headon_go", int'(game_over), 1);

      // P0 runs off the right edge on tick 160; P1 steered clear.
      occ_force0 = 1'b1;
      do_start();
      tick();
      for (int t = 1; t <= 160; t++) begin
         if (t == 2) pulse(2'b10, 4'b1100);
         if (t == 102) pulse(2'b10, 4'b1000);
         base = plot_cnt;
         tick();
         if (t == 159) chk("edge_p0_at_159", int'(head_x[7:0]), 159);
      end
`ifdef TRON_BORDER_WRAP_EN
      chk("wrap_nplots", plot_cnt - base, 2);
      chk_plot("wrap_p0", base, 0, 0, 5);
      chk_plot("wrap_p1", base + 1, 99, 19, 2);
      chk("wrap_crash", int'(crash), 0);
      chk("wrap_go", int'(game_over), 0);
`else
      chk("edge_nplots", plot_cnt - base, 1);
      chk_plot("edge_p1", base, 99, 19, 2);
      chk("edge_crash", int'(crash), 1);
      chk("edge_go", int'(game_over), 1);
      chk("edge_p0_head", int'(head_x[7:0]), 159);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
